// File: rtl/conv2d_tile_engine.sv
// Strided valid-mode 2-D convolution of one tile with one kernel, plus bias and output saturation.
// Products are issued to LANES external DSPs. Define CONV_RELU_EN to clamp negative results to zero.
module conv2d_tile_engine #(
  parameter int DATA_W  = 8,
  parameter int IN_DIM  = 6,
  parameter int K_DIM   = 3,
  parameter int STRIDE  = 1,
  parameter int LANES   = 5,
  parameter int DSP_LAT = 1,
  parameter int ACC_W   = 32,
  parameter int OUT_W   = 16,
  localparam int OUT_DIM = (IN_DIM - K_DIM) / STRIDE + 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic signed [ACC_W-1:0]           bias,
  input  logic [IN_DIM*IN_DIM*DATA_W-1:0]   input_tile,
  input  logic [K_DIM*K_DIM*DATA_W-1:0]     kernel,
  output logic [OUT_DIM*OUT_DIM*OUT_W-1:0]  c_out,
  output logic [LANES*18-1:0]               dsp_a,
  output logic [LANES*18-1:0]               dsp_b,
  output logic                              dsp_ce,
  input  logic [LANES*37-1:0]               dsp_p,
  output logic                              busy,
  output logic                              done
);
  localparam int KK    = K_DIM * K_DIM;
  localparam int BEATS = (KK + LANES - 1) / LANES;
  localparam int NPIX  = OUT_DIM * OUT_DIM;
  localparam int BW    = $clog2(BEATS + 1);
  localparam int DW    = $clog2(OUT_DIM + 1);
  localparam int PW    = $clog2(NPIX + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((longint'(1) <<< (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  if ((IN_DIM - K_DIM) % STRIDE != 0 || K_DIM > IN_DIM || DATA_W > 18 || DSP_LAT < 1) begin : g_bad_cfg
    $error("conv2d_tile_engine: illegal parameter combination");
  end

  logic [1:0]                       state;
  logic [IN_DIM*IN_DIM*DATA_W-1:0]  in_r;
  logic [KK*DATA_W-1:0]             ker_r;
  logic signed [ACC_W-1:0]          bias_r, acc, beat_sum, total;
  logic signed [36:0]               p_el;
  logic [BW-1:0]                    beat;
  logic [DW-1:0]                    row, col;
  logic [PW-1:0]                    wr_pix;
  logic [DSP_LAT-1:0]               vld_sr, first_sr, last_sr;
  logic                             beat_last, issue_done, ret_vld, ret_first, ret_last;

  assign dsp_ce     = (state == S_ISSUE);
  assign busy       = (state == S_ISSUE) || (state == S_DRAIN);
  assign done       = (state == S_DONE);
  assign beat_last  = (beat == BW'(BEATS - 1));
  assign issue_done = dsp_ce && beat_last && (row == DW'(OUT_DIM - 1)) && (col == DW'(OUT_DIM - 1));
  assign ret_vld    = vld_sr[DSP_LAT-1];
  assign ret_first  = first_sr[DSP_LAT-1];
  assign ret_last   = last_sr[DSP_LAT-1];
  assign total      = (ret_first ? bias_r : acc) + beat_sum;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin : operand_mux
    int k, ir, ic;
    logic signed [DATA_W-1:0] a_el, b_el;
    dsp_a = '0;
    dsp_b = '0;
    k = 0; ir = 0; ic = 0;
    a_el = '0; b_el = '0;
    if (state == S_ISSUE) begin
      for (int l = 0; l < LANES; l++) begin
        k = int'(beat) * LANES + l;
        if (k < KK) begin
          ir   = int'(row) * STRIDE + k / K_DIM;
          ic   = int'(col) * STRIDE + k % K_DIM;
          a_el = in_r[(ir * IN_DIM + ic) * DATA_W +: DATA_W];
          b_el = ker_r[k * DATA_W +: DATA_W];
          dsp_a[l*18 +: 18] = 18'(a_el);
          dsp_b[l*18 +: 18] = 18'(b_el);
        end
      end
    end
  end

  always_comb begin : lane_sum
    beat_sum = '0;
    p_el     = '0;
    for (int l = 0; l < LANES; l++) begin
      p_el     = dsp_p[l*37 +: 37];
      beat_sum = beat_sum + ACC_W'(p_el);
    end
  end

  function automatic logic [OUT_W-1:0] clamp(input logic signed [ACC_W-1:0] v);
    logic [OUT_W-1:0] r;
    if (v > SAT_MAX)      r = SAT_MAX[OUT_W-1:0];
    else if (v < SAT_MIN) r = SAT_MIN[OUT_W-1:0];
    else                  r = v[OUT_W-1:0];
`ifdef CONV_RELU_EN
    if (v[ACC_W-1]) r = '0;
`else
`endif
    return r;
  endfunction

  // NOTE: the job snapshot has no reset; it is only consumed after start has loaded it.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      in_r   <= input_tile;
      ker_r  <= kernel;
      bias_r <= bias;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      beat     <= '0;
      row      <= '0;
      col      <= '0;
      wr_pix   <= '0;
      acc      <= '0;
      c_out    <= '0;
      vld_sr   <= '0;
      first_sr <= '0;
      last_sr  <= '0;
    end else begin
      vld_sr[0]   <= dsp_ce;
      first_sr[0] <= dsp_ce && (beat == '0);
      last_sr[0]  <= dsp_ce && beat_last;
      for (int i = 1; i < DSP_LAT; i++) begin
        vld_sr[i]   <= vld_sr[i-1];
        first_sr[i] <= first_sr[i-1];
        last_sr[i]  <= last_sr[i-1];
      end

      // Returns arrive in issue order, so a running write index addresses the pixel.
      if (ret_vld) acc <= total;
      if (ret_vld && ret_last) begin
        c_out[int'(wr_pix)*OUT_W +: OUT_W] <= clamp(total);
        wr_pix <= wr_pix + 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_ISSUE;
            beat   <= '0;
            row    <= '0;
            col    <= '0;
            wr_pix <= '0;
          end
        end
        S_ISSUE: begin
          if (beat_last) begin
            beat <= '0;
            if (col == DW'(OUT_DIM - 1)) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end else begin
            beat <= beat + 1'b1;
          end
          if (issue_done) state <= S_DRAIN;
        end
        S_DRAIN: if (ret_vld && ret_last && wr_pix == PW'(NPIX - 1)) state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv2d_tile_engine.sv
// Directed bench: default 6x6/3x3/5-lane engine plus a 7x7 stride-2, 9-lane, 3-cycle-DSP instance.
// Expected values are hand-derived closed forms for ramp and constant tiles.
module tb_conv2d_tile_engine;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: defaults
  logic               start_a;
  logic signed [31:0] bias_a;
  logic [6*6*8-1:0]   tile_a;
  logic [9*8-1:0]     ker_a;
  logic [16*16-1:0]   c_a;
  logic [5*18-1:0]    da_a, db_a;
  logic               ce_a, busy_a, done_a;
  logic [5*37-1:0]    prod_a, p_a;
  logic signed [36:0] ea_a, eb_a;

  // Instance B: 7x7, stride 2, 9 lanes, DSP latency 3
  logic               start_b;
  logic signed [31:0] bias_b;
  logic [7*7*8-1:0]   tile_b;
  logic [9*8-1:0]     ker_b;
  logic [9*16-1:0]    c_b;
  logic [9*18-1:0]    da_b, db_b;
  logic               ce_b, busy_b, done_b;
  logic [9*37-1:0]    prod_b, pb1, pb2, pb3;
  logic signed [36:0] ea_b, eb_b;

  int n_checks = 0;
  int n_pass   = 0;
  logic [5*18-1:0] first_da, first_db;
  int lane4_bad;

  conv2d_tile_engine #(.DATA_W(8), .IN_DIM(6), .K_DIM(3), .STRIDE(1), .LANES(5),
                       .DSP_LAT(1), .ACC_W(32), .OUT_W(16)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .bias(bias_a), .input_tile(tile_a), .kernel(ker_a),
    .c_out(c_a), .dsp_a(da_a), .dsp_b(db_a), .dsp_ce(ce_a), .dsp_p(p_a), .busy(busy_a), .done(done_a)
  );

  conv2d_tile_engine #(.DATA_W(8), .IN_DIM(7), .K_DIM(3), .STRIDE(2), .LANES(9),
                       .DSP_LAT(3), .ACC_W(32), .OUT_W(16)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .bias(bias_b), .input_tile(tile_b), .kernel(ker_b),
    .c_out(c_b), .dsp_a(da_b), .dsp_b(db_b), .dsp_ce(ce_b), .dsp_p(pb3), .busy(busy_b), .done(done_b)
  );

  // Ideal external DSPs: full signed product, fixed latency
  always_comb begin
    prod_a = '0; ea_a = '0; eb_a = '0;
    for (int l = 0; l < 5; l++) begin
      ea_a = signed'(da_a[l*18 +: 18]);
      eb_a = signed'(db_a[l*18 +: 18]);
      prod_a[l*37 +: 37] = ea_a * eb_a;
    end
  end
  always_comb begin
    prod_b = '0; ea_b = '0; eb_b = '0;
    for (int l = 0; l < 9; l++) begin
      ea_b = signed'(da_b[l*18 +: 18]);
      eb_b = signed'(db_b[l*18 +: 18]);
      prod_b[l*37 +: 37] = ea_b * eb_b;
    end
  end
  always @(posedge clk) begin
    p_a <= prod_a;
    pb1 <= prod_b;
    pb2 <= pb1;
    pb3 <= pb2;
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int relu(input int v);
`ifdef CONV_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic int pix_a(input int idx);
    logic signed [15:0] v;
    v = c_a[idx*16 +: 16];
    return int'(v);
  endfunction

  function automatic int pix_b(input int idx);
    logic signed [15:0] v;
    v = c_b[idx*16 +: 16];
    return int'(v);
  endfunction

  task automatic fill_a(input bit ramp, input int v, input int kv);
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++)
        tile_a[(r*6+c)*8 +: 8] = ramp ? 8'(r + c) : 8'(v);
    for (int i = 0; i < 9; i++) ker_a[i*8 +: 8] = 8'(kv);
  endtask

  // One default-instance job. glitch_c pulses start, chg_c corrupts the tile, abort_c asserts rst.
  task automatic run_a(input int glitch_c, input int chg_c, input int abort_c,
                       output int done_c, output int ce_n);
    int c;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    c = 1; done_c = -1; ce_n = 0; lane4_bad = 0;
    while (c < 100) begin
      start_a = (c == glitch_c);
      if (c == 1) begin
        first_da = da_a;
        first_db = db_a;
        check("busy_cycle1", longint'(busy_a), 1);
      end
      if (c == chg_c) fill_a(1'b0, 127, 1);
      if (ce_a) begin
        ce_n++;
        if (ce_n % 2 == 0 && (da_a[4*18 +: 18] != '0 || db_a[4*18 +: 18] != '0)) lane4_bad++;
      end
      if (done_a) begin
        done_c = c;
        break;
      end
      if (c == abort_c) begin
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_c_out_zero", longint'(|c_a), 0);
        check("abort_busy", longint'(busy_a), 0);
        check("abort_dsp_ce", longint'(ce_a), 0);
        check("abort_dsp_ops", longint'(|{da_a, db_a}), 0);
        check("abort_done", longint'(done_a), 0);
        @(negedge clk); rst = 1'b0;
        start_a = 1'b0;
        return;
      end
      @(negedge clk); c++;
    end
    start_a = 1'b0;
    @(negedge clk);
    check("done_one_cycle", longint'(done_a), 0);
  endtask

  initial begin
    int dc, cn;
    logic signed [17:0] op;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    bias_a = '0; bias_b = '0;
    fill_a(1'b1, 0, 1);
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++)
        tile_b[(r*7+c)*8 +: 8] = 8'(r + c);
    for (int i = 0; i < 9; i++) ker_b[i*8 +: 8] = 8'd1;
    #12;
    check("reset_c_out", longint'(|c_a), 0);
    check("reset_busy", longint'(busy_a), 0);
    check("reset_done", longint'(done_a), 0);
    check("reset_dsp_ce", longint'(ce_a), 0);
    @(negedge clk); rst = 1'b0;

    // Ramp, unit kernel: c[i][j] = 9(i+j)+18
    run_a(-1, -1, -1, dc, cn);
    check("ramp_done_cycle", dc, 34);
    check("ramp_ce_cycles", cn, 32);
    check("lane4_idle", lane4_bad, 0);
    op = first_da[2*18 +: 18]; check("beat0_lane2_a", op, 2);
    op = first_da[3*18 +: 18]; check("beat0_lane3_a", op, 1);
    op = first_db[0 +: 18];    check("beat0_lane0_b", op, 1);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        check($sformatf("ramp_c%0d%0d", i, j), pix_a(i*4+j), 9*(i+j)+18);

    // Negative bias
    bias_a = -32'sd20;
    run_a(-1, -1, -1, dc, cn);
    check("bias_c00", pix_a(0), relu(-2));
    check("bias_c33", pix_a(15), 52);

    // Positive and negative saturation
    bias_a = '0;
    fill_a(1'b0, 127, 127);
    run_a(-1, -1, -1, dc, cn);
    check("satp_c00", pix_a(0), 32767);
    check("satp_c21", pix_a(9), 32767);
    fill_a(1'b0, 127, -128);
    run_a(-1, -1, -1, dc, cn);
    check("satn_c00", pix_a(0), relu(-32768));
    check("satn_c33", pix_a(15), relu(-32768));

    // Tile changed in cycle 2: results follow the snapshot
    fill_a(1'b1, 0, 1);
    run_a(-1, 2, -1, dc, cn);
    check("snap_c00", pix_a(0), 18);
    check("snap_c23", pix_a(11), 63);
    check("snap_c33", pix_a(15), 72);

    // Start while busy is ignored
    fill_a(1'b1, 0, 1);
    run_a(5, -1, -1, dc, cn);
    check("glitch_done_cycle", dc, 34);
    check("glitch_ce_cycles", cn, 32);
    check("glitch_c33", pix_a(15), 72);

    // Reset in cycle 10, then a fresh job with bias 7
    run_a(-1, -1, 10, dc, cn);
    bias_a = 32'sd7;
    run_a(-1, -1, -1, dc, cn);
    check("post_rst_done_cycle", dc, 34);
    check("post_rst_c11", pix_a(5), 43);
    check("post_rst_c30", pix_a(12), 52);

    // Instance B: c[i][j] = 9(2i+2j)+18, 9 beats, done in cycle 13
    begin
      int c;
      @(negedge clk); start_b = 1'b1;
      @(negedge clk); start_b = 1'b0;
      c = 1; dc = -1; cn = 0;
      while (c < 100) begin
        if (ce_b) cn++;
        if (done_b) begin
          dc = c;
          break;
        end
        @(negedge clk); c++;
      end
      check("b_done_cycle", dc, 13);
      check("b_ce_cycles", cn, 9);
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          check($sformatf("b_c%0d%0d", i, j), pix_b(i*3+j), 9*(2*i+2*j)+18);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
